// File: rtl/dct_sequencer_if.sv
// dct_sequencer bus bundle: sample stream in, coefficient stream out,
// and the Avalon-MM master port towards avalon_dct.
interface dct_sequencer_if #(
  parameter int NBITS = 16,
  parameter int ADDRW = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_data;
  logic [ADDRW-1:0] out_index;
  logic             out_last;
  logic [ADDRW-1:0] dct_addr;
  logic             dct_read;
  logic             dct_write;
  logic [NBITS-1:0] dct_writedata;
  logic [NBITS-1:0] dct_readdata;
  logic             dct_done;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_index, out_last,
    input  out_ready,
    output dct_addr, dct_read, dct_write, dct_writedata,
    input  dct_readdata, dct_done
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_index, out_last,
    output out_ready,
    input  dct_addr, dct_read, dct_write, dct_writedata,
    output dct_readdata, dct_done
  );
endinterface

// File: rtl/dct_sequencer.sv
// dct_sequencer: programs avalon_dct, streams samples in,
// reads back coefficients and streams them out.
module dct_sequencer #(
  parameter int NBITS = 16,
  parameter int ADDRW = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             start,
  input  logic [NBITS-1:0] cfg_m,
  input  logic [ADDRW-1:0] cfg_n,
  input  logic [ADDRW-1:0] cfg_k,
  output logic             busy,
  output logic             done,
  output logic             err,
  dct_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, WR_M, WR_N, WR_S, RD, OUT, FIN
  } state_t;

  state_t           state;
  logic [ADDRW-1:0] n_q;
  logic [ADDRW-1:0] k_q;
  logic [ADDRW-1:0] cnt;
  logic [ADDRW-1:0] idx;
  logic             wr_q;
  logic [NBITS-1:0] wd_q;
  logic [ADDRW-1:0] addr_q;
  logic             rd_q;
  logic             rdy_q;
  logic             ov_q;
  logic [NBITS-1:0] od_q;
  logic [ADDRW-1:0] oi_q;
  logic             ol_q;
  logic             cfg_bad;
  logic             in_hs;

  assign cfg_bad = (cfg_n == '0) || (cfg_k == '0) ||
                   (cfg_k > cfg_n);
  assign in_hs   = (state == WR_S) && bus.in_valid;

  // sample pushes pass straight through so one write per cycle is possible
  assign bus.in_ready      = rdy_q;
  assign bus.dct_write     = wr_q | in_hs;
  assign bus.dct_writedata = (state == WR_S) ? bus.in_data : wd_q;
  assign bus.dct_addr      = addr_q;
  assign bus.dct_read      = rd_q;
  assign bus.out_valid     = ov_q;
  assign bus.out_data      = od_q;
  assign bus.out_index     = oi_q;
  assign bus.out_last      = ol_q;

  // sequencer FSM with registered strobes and stream outputs
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state  <= IDLE;
      n_q    <= '0;
      k_q    <= '0;
      cnt    <= '0;
      idx    <= '0;
      wr_q   <= 1'b0;
      wd_q   <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      rdy_q  <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      oi_q   <= '0;
      ol_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q <= cfg_n;
            k_q <= cfg_k;
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              state  <= WR_M;
              busy   <= 1'b1;
              cnt    <= '0;
              idx    <= '0;
              wr_q   <= 1'b1;
              addr_q <= ADDRW'(3);
              wd_q   <= cfg_m;
            end
          end
        end
        WR_M: begin
          state  <= WR_N;
          addr_q <= '0;
          wd_q   <= NBITS'(n_q);
        end
        WR_N: begin
          state  <= WR_S;
          wr_q   <= 1'b0;
          wd_q   <= '0;
          addr_q <= ADDRW'(1);
          rdy_q  <= 1'b1;
        end
        WR_S: begin
          if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == n_q - 1'b1) begin
              state  <= RD;
              rdy_q  <= 1'b0;
              rd_q   <= 1'b1;
              addr_q <= idx;
            end
          end
        end
        RD: begin
          if (bus.dct_done) begin
            state <= OUT;
            rd_q  <= 1'b0;
            ov_q  <= 1'b1;
            od_q  <= bus.dct_readdata;
            oi_q  <= idx;
            ol_q  <= (idx == k_q - 1'b1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            ov_q <= 1'b0;
            if (ol_q) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state  <= RD;
              idx    <= idx + 1'b1;
              rd_q   <= 1'b1;
              addr_q <= idx + 1'b1;
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy   <= 1'b0;
          addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_sequencer.sv
// tb_dct_sequencer: directed vectors against a behavioural
// avalon_dct slave and stream source/sink.
module tb_dct_sequencer;

  logic        Clock;
  logic        ResetN;
  logic        start;
  logic [15:0] cfg_m;
  logic [7:0]  cfg_n;
  logic [7:0]  cfg_k;
  logic        busy;
  logic        done;
  logic        err;

  dct_sequencer_if #(.NBITS(16), .ADDRW(8)) bus ();

  dct_sequencer #(.NBITS(16), .ADDRW(8)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .start  (start),
    .cfg_m  (cfg_m),
    .cfg_n  (cfg_n),
    .cfg_k  (cfg_k),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] m;
    logic [7:0]  n;
    logic [7:0]  k;
    bit          bubbles;
    int          stall;
    int          lat;
    bit          poke;
    bit          exp_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  wr_a[$];
  logic [15:0] wr_d[$];
  int          rd_a[$];
  int          rd_t[$];
  int          o_i[$];
  logic [15:0] o_d[$];
  bit          o_l[$];
  int          viol;
  int          err_cyc;
  int          done_cyc;
  int          busy_cyc;
  int          first_wr;
  int          src_idx;

  function automatic logic [15:0] samp(input int i);
    case (i)
      0: return 16'h0200;
      1: return 16'h0100;
      2: return 16'hFF00;
      3: return 16'hFE00;
      default: return 16'(i * 257 + 16);
    endcase
  endfunction

  function automatic logic [15:0] coef(input int k);
    return 16'hA000 ^ 16'(k * 273);
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {8'h0, busy, done, err, bus.in_ready, bus.out_valid,
            bus.out_data, bus.out_index, bus.out_last, bus.dct_addr,
            bus.dct_read, bus.dct_write, bus.dct_writedata};
  endfunction

  // one transform: drive at negedge, settle, then log what the
  // next rising edge will sample
  task automatic run(input vec_t v, input int rst_at);
    int  stall_cnt = 0;
    int  rd_cnt = 0;
    int  post = 0;
    int  rst_t = 0;
    bit  phase = 0;
    bit  prev_stall = 0;
    bit  prev_read = 0;
    bit  fin = 0;
    bit  poked = 0;
    bit  rst_fired = 0;
    bit  rst_chk = 0;
    logic [15:0] pd = '0;
    logic [7:0]  pi = '0;
    wr_a.delete(); wr_d.delete(); rd_a.delete(); rd_t.delete();
    o_i.delete(); o_d.delete(); o_l.delete();
    viol = 0; err_cyc = 0; done_cyc = 0; busy_cyc = 0;
    first_wr = -1; src_idx = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge Clock);
      if (rst_fired && !rst_chk) begin
        check("reset_midop_outputs", outs(), 64'h0);
        rst_chk = 1;
      end
      ResetN = 1'b1;
      start = (t == 0);
      if (t == 0) begin
        cfg_m = v.m; cfg_n = v.n; cfg_k = v.k;
      end else begin
        cfg_m = 16'h7777; cfg_n = 8'hFF; cfg_k = 8'h01;
      end
      if (v.poke && !poked && bus.dct_read) begin
        start = 1'b1;
        poked = 1;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 16'hDEAD;
      if (busy && src_idx < int'(v.n)) begin
        phase = !phase;
        bus.in_valid = v.bubbles ? phase : 1'b1;
        if (bus.in_valid) bus.in_data = samp(src_idx);
      end
      if (rst_at > 0 && !rst_fired && src_idx == rst_at) begin
        ResetN = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        rst_fired = 1;
        rst_t = t;
      end
      bus.dct_done = bus.dct_read && rd_cnt >= v.lat;
      bus.dct_readdata = bus.dct_done ? coef(int'(bus.dct_addr))
                                      : 16'h0BAD;
      bus.out_ready = bus.out_valid && stall_cnt >= v.stall;
      #1;
      if (bus.dct_write) begin
        wr_a.push_back(bus.dct_addr);
        wr_d.push_back(bus.dct_writedata);
        if (first_wr < 0) first_wr = t;
      end
      if (bus.dct_write && bus.dct_addr == 8'd1 && !bus.in_valid)
        viol++;
      if (bus.in_valid && bus.in_ready) src_idx++;
      if (bus.dct_read && !prev_read) begin
        rd_a.push_back(int'(bus.dct_addr));
        rd_t.push_back(t);
      end
      prev_read = bus.dct_read;
      rd_cnt = (bus.dct_read && !bus.dct_done) ? rd_cnt + 1 : 0;
      if (prev_stall && !(bus.out_valid && bus.out_data == pd &&
                          bus.out_index == pi))
        viol++;
      if (bus.out_valid && bus.dct_read) viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pi = bus.out_index;
      if (bus.out_valid && bus.out_ready) begin
        o_i.push_back(int'(bus.out_index));
        o_d.push_back(bus.out_data);
        o_l.push_back(bus.out_last);
        stall_cnt = 0;
      end else if (bus.out_valid) begin
        stall_cnt++;
      end
      if (err)  err_cyc++;
      if (done) done_cyc++;
      if (busy) busy_cyc++;
      if (done) fin = 1;
      if (fin) post++;
      if (post >= 3) break;
      if (v.exp_err && t >= 6) break;
      if (rst_chk && t >= rst_t + 6) break;
    end
    @(negedge Clock);
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dct_done = 1'b0;
    if (rst_at > 0 && !rst_chk)
      check("reset_midop_reached", 0, 1);
  endtask

  task automatic check_vec(input int id, input vec_t v);
    string p;
    int bad;
    p = $sformatf("v%0d_", id);
    if (v.exp_err) begin
      check({p, "err_pulse"}, err_cyc, 1);
      check({p, "err_busy"}, busy_cyc, 0);
      check({p, "err_access"}, wr_a.size() + rd_a.size(), 0);
      check({p, "err_done"}, done_cyc, 0);
      return;
    end
    check({p, "no_err"}, err_cyc, 0);
    check({p, "wr_count"}, wr_a.size(), int'(v.n) + 2);
    bad = 0;
    foreach (wr_a[i]) begin
      logic [7:0]  ea;
      logic [15:0] ed;
      ea = (i == 0) ? 8'd3 : (i == 1) ? 8'd0 : 8'd1;
      ed = (i == 0) ? v.m : (i == 1) ? 16'(v.n) : samp(i - 2);
      if (wr_a[i] !== ea || wr_d[i] !== ed) bad++;
    end
    check({p, "wr_content"}, bad, 0);
    check({p, "first_wr_tick"}, first_wr, 1);
    check({p, "rd_count"}, rd_a.size(), int'(v.k));
    bad = 0;
    foreach (rd_a[i]) if (rd_a[i] != i) bad++;
    check({p, "rd_addr"}, bad, 0);
    check({p, "out_count"}, o_i.size(), int'(v.k));
    bad = 0;
    foreach (o_i[i])
      if (o_i[i] != i || o_d[i] !== coef(i) ||
          o_l[i] != (i == int'(v.k) - 1))
        bad++;
    check({p, "out_content"}, bad, 0);
    check({p, "protocol"}, viol, 0);
    check({p, "done_pulse"}, done_cyc, 1);
    check({p, "busy_after"}, busy, 0);
    if (v.lat == 0 && v.stall == 0) begin
      bad = 0;
      for (int i = 1; i < rd_t.size(); i++)
        if (rd_t[i] - rd_t[i-1] != 2) bad++;
      check({p, "coef_period"}, bad, 0);
    end
  endtask

  vec_t vecs[7];
  vec_t nom;

  initial begin
    vecs[0] = '{16'd6, 8'd4,  8'd4,  0, 0, 3, 0, 0};
    vecs[1] = '{16'd6, 8'd8,  8'd8,  1, 5, 3, 0, 0};
    vecs[2] = '{16'd4, 8'd20, 8'd10, 0, 0, 0, 0, 0};
    vecs[3] = '{16'd6, 8'd0,  8'd1,  0, 0, 0, 0, 1};
    vecs[4] = '{16'd6, 8'd4,  8'd0,  0, 0, 0, 0, 1};
    vecs[5] = '{16'd6, 8'd4,  8'd5,  0, 0, 0, 0, 1};
    vecs[6] = '{16'd6, 8'd4,  8'd4,  0, 0, 3, 1, 0};
    nom = vecs[0];

    ResetN = 1'b0;
    start = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.dct_done = 1'b0;
    bus.dct_readdata = '0;
    repeat (2) @(negedge Clock);
    check("reset_state", outs(), 64'h0);
    ResetN = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 7; i++) begin
      run(vecs[i], 0);
      check_vec(i, vecs[i]);
    end

    run(nom, 2);
    check("reset_midop_writes", wr_a.size(), 4);
    check("reset_midop_reads", rd_a.size(), 0);
    check("reset_midop_busy", busy, 0);
    run(nom, 0);
    check_vec(10, nom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
